// File: rtl/commit_trace_sequencer_if.sv
// Trace stream bundle: head entry plus valid/ready toward the sink.
// master = sequencer drives valid/data, slave = sink drives ready.
interface commit_trace_sequencer_if #(
    parameter int XLEN = 64
);
    logic            valid;
    logic            ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [2:0]      cls;
    logic [15:0]     seq;

    modport master (
        output valid, instr, pc, cls, seq,
        input  ready
    );

    modport slave (
        input  valid, instr, pc, cls, seq,
        output ready
    );
endinterface

// File: rtl/commit_trace_sequencer.sv
// Serializes multi-port retires into one tagged trace stream.
// Ports: clk_i/rst_ni, enable_i, flush_i, commit_*_i, trace (master), drop_cnt_o, overflow_o, busy_o.
module commit_trace_sequencer #(
    parameter int NR_COMMIT_PORTS = 2,
    parameter int DEPTH           = 8,
    parameter int XLEN            = 64
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            enable_i,
    input  logic                            flush_i,
    input  logic [NR_COMMIT_PORTS-1:0]      commit_valid_i,
    input  logic [NR_COMMIT_PORTS*32-1:0]   commit_instr_i,
    input  logic [NR_COMMIT_PORTS*XLEN-1:0] commit_pc_i,
    commit_trace_sequencer_if.master        trace,
    output logic [15:0]                     drop_cnt_o,
    output logic                            overflow_o,
    output logic                            busy_o
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        OFF,
        RUN,
        DRAIN
    } state_e;

    state_e state_q, state_d;

    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [15:0]   seq_q, seq_d;
    logic [15:0]   drop_q, drop_d;
    logic          ovf_q, ovf_d;

    logic [31:0]     instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [2:0]      cls_mem   [DEPTH];
    logic [15:0]     seq_mem   [DEPTH];

    logic          valid;
    logic          pop;
    logic          run;
    logic          fits;
    logic          push;
    logic [AW:0]   n;
    logic [AW:0]   free;
    logic [16:0]   drop_sum;
    logic [AW-1:0] off [NR_COMMIT_PORTS];
    logic [15:0]   sof [NR_COMMIT_PORTS];

    function automatic logic [2:0] cls_of(input logic [31:0] ins);
        logic [2:0] c;
        logic [6:0] op;
        c  = 3'd0;
        op = ins[6:0];
        unique case (1'b1)
            ins[1:0] != 2'b11:                 c = 3'd6;
            op == 7'b0000011,
            op == 7'b0000111:                  c = 3'd1;
            op == 7'b0100011,
            op == 7'b0100111:                  c = 3'd2;
            op == 7'b1100011,
            op == 7'b1101111,
            op == 7'b1100111:                  c = 3'd3;
            op == 7'b1110011:                  c = 3'd4;
            op == 7'b0101111:                  c = 3'd5;
            default:                           c = 3'd0;
        endcase
        return c;
    endfunction

    assign valid = (count_q != '0);
    assign pop   = valid & trace.ready;
    assign run   = (state_q == RUN);

    // Slot/sequence offset of each port = number of valid ports below it.
    always_comb begin
        n = '0;
        for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
            off[p] = n[AW-1:0];
            sof[p] = 16'(n);
            n      = n + (AW+1)'(commit_valid_i[p]);
        end
    end

    // A head popped this cycle frees its slot for the incoming group.
    assign free     = (AW+1)'(DEPTH) - count_q + (AW+1)'(pop);
    assign fits     = (n <= free);
    assign push     = run & fits & (n != '0) & ~flush_i;
    assign drop_sum = {1'b0, drop_q} + 17'(n);

    always_comb begin
        count_d = count_q - (AW+1)'(pop) + (push ? n : '0);
        wptr_d  = wptr_q + (push ? n[AW-1:0] : '0);
        rptr_d  = rptr_q + AW'(pop);
        if (flush_i) begin
            count_d = '0;
            wptr_d  = '0;
            rptr_d  = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        drop_d  = drop_q;
        ovf_d   = ovf_q;
        if (run) begin
            seq_d = seq_q + 16'(n);
            if (!fits) begin
                drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
                ovf_d  = 1'b1;
            end
        end
        unique case (state_q)
            OFF: begin
                if (enable_i) begin
                    state_d = RUN;
                    seq_d   = '0;
                    drop_d  = '0;
                    ovf_d   = 1'b0;
                end
            end
            RUN: begin
                if (!enable_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (count_d == '0) state_d = OFF;
                else if (enable_i) state_d = RUN;
            end
            default: state_d = OFF;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= OFF;
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            seq_q   <= '0;
            drop_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            seq_q   <= seq_d;
            drop_q  <= drop_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
                if (commit_valid_i[p]) begin
                    instr_mem[wptr_q + off[p]] <= commit_instr_i[32*p +: 32];
                    pc_mem[wptr_q + off[p]]    <= commit_pc_i[XLEN*p +: XLEN];
                    cls_mem[wptr_q + off[p]]   <= cls_of(commit_instr_i[32*p +: 32]);
                    seq_mem[wptr_q + off[p]]   <= seq_q + sof[p];
                end
            end
        end
    end

    // Head fields are forced to zero while empty so nothing stale leaks out.
    assign trace.valid = valid;
    assign trace.instr = valid ? instr_mem[rptr_q] : '0;
    assign trace.pc    = valid ? pc_mem[rptr_q]    : '0;
    assign trace.cls   = valid ? cls_mem[rptr_q]   : '0;
    assign trace.seq   = valid ? seq_mem[rptr_q]   : '0;

    assign drop_cnt_o = drop_q;
    assign overflow_o = ovf_q;
    assign busy_o     = (state_q != OFF);
endmodule
